// File: rtl/shift_out_sched.sv
// Round-robin owner of a shared PISO shift register: captures the winner's word,
// paces the shift one bit every DIV clocks (LSB first) and acks the owner at frame end.
module shift_out_sched #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int DIV   = 1,
  parameter int GAP   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  tx_active,
  output logic                  sh_load,
  output logic                  sh_enable,
  output logic [WIDTH-1:0]      sh_data
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d, ack_q, ack_d;
  logic              busy_q, busy_d, tx_active_q, tx_active_d;
  logic              sh_load_q, sh_load_d, sh_enable_q, sh_enable_d;
  logic [WIDTH-1:0]  sh_data_q, sh_data_d;
  logic [PW-1:0]     last_q, last_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     div_q, div_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [NREQ-1:0]   elig;
  logic [PW-1:0]     cand, win_idx;
  logic              win_found;

  // A requester whose ack is on the wire this cycle is not eligible again yet.
  assign elig = req & ~ack_q;

  // Scan from lowest to highest priority so the nearest requester after last_q wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = PW'((int'(last_q) + k) % NREQ);
      if (elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    sh_load_d   = 1'b0;
    sh_data_d   = sh_data_q;
    last_d      = last_q;
    bit_d       = bit_q;
    div_d       = div_q;
    gap_d       = gap_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_LOAD;
          grant_d   = NREQ'(1) << win_idx;
          sh_data_d = req_data[int'(win_idx)*WIDTH +: WIDTH];
          sh_load_d = 1'b1;
          last_d    = win_idx;
        end
      end
      S_LOAD: begin
        bit_d = '0;
        div_d = '0;
        gap_d = '0;
        if (abort) begin
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
          grant_d = '0;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        gap_d = '0;
        if (abort) begin
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
          grant_d = '0;
        end else if (div_q == DW'(DIV - 1)) begin
          if (bit_q == BW'(WIDTH - 1)) begin
            state_d = (GAP > 0) ? S_GAP : S_IDLE;
            ack_d   = grant_q;
            grant_d = '0;
          end else begin
            bit_d = bit_q + BW'(1);
            div_d = '0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered, so they are derived from the next-cycle counters.
    tx_active_d = (state_d == S_SHIFT);
    busy_d      = (state_d != S_IDLE);
    sh_enable_d = (state_d == S_SHIFT) && (div_d == DW'(DIV - 1)) &&
                  (bit_d != BW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      tx_active_q <= 1'b0;
      sh_load_q   <= 1'b0;
      sh_enable_q <= 1'b0;
      sh_data_q   <= '0;
      last_q      <= PW'(NREQ - 1);
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      tx_active_q <= tx_active_d;
      sh_load_q   <= sh_load_d;
      sh_enable_q <= sh_enable_d;
      sh_data_q   <= sh_data_d;
      last_q      <= last_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign tx_active = tx_active_q;
  assign sh_load   = sh_load_q;
  assign sh_enable = sh_enable_q;
  assign sh_data   = sh_data_q;

endmodule
